// File: rtl/cart_mapper.sv
// Cartridge bank mapper: decodes 6502 cartridge reads, tracks the bank
// register through F8/F6/F4 hotspots and fetches each byte from the SD
// pager with an IDLE -> ISSUE -> WAIT handshake.
module cart_mapper #(
    parameter int SLOT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [12:0]          cpu_address,
    input  logic                 cpu_strobe,
    output logic [7:0]           cpu_data,
    output logic                 cpu_ready,
    input  logic [1:0]           scheme,
    input  logic [SLOT_BITS-1:0] slot,
    output logic [2:0]           bank,
    output logic                 overrun,
    output logic [23:0]          sd_address,
    output logic                 sd_enable,
    input  logic [7:0]           sd_data,
    input  logic                 sd_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] SCHEME_4K  = 2'd0;
    localparam logic [1:0] SCHEME_F8  = 2'd1;
    localparam logic [1:0] SCHEME_F6  = 2'd2;
    localparam logic [1:0] SCHEME_F4  = 2'd3;

    state_t      state_reg;
    logic [2:0]  bank_reg;
    logic [7:0]  cpu_data_reg;
    logic        cpu_ready_reg;
    logic        overrun_reg;
    logic [23:0] sd_address_reg;
    logic        sd_enable_reg;

    logic        cart_sel;
    logic        cart_strobe;
    logic [7:0]  hit_f4;
    logic [3:0]  hit_f6;
    logic [1:0]  hit_f8;
    logic        hot_hit;
    logic [2:0]  hot_bank;
    logic [2:0]  bank_next;
    logic [2:0]  bank_eff;
    logic [23:0] fetch_address;

    // A12 high is the cartridge window; anything below belongs to the console.
    assign cart_sel    = cpu_address[12];
    assign cart_strobe = cpu_strobe && cart_sel;

    // One comparator per hotspot location: hotspot gi of each scheme selects bank gi.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hotspot
            assign hit_f4[gi] = (cpu_address[11:0] == (12'hFF4 + 12'(gi)));
            if (gi < 4) begin : g_f6
                assign hit_f6[gi] = (cpu_address[11:0] == (12'hFF6 + 12'(gi)));
            end
            if (gi < 2) begin : g_f8
                assign hit_f8[gi] = (cpu_address[11:0] == (12'hFF8 + 12'(gi)));
            end
        end
    endgenerate

    // Encode which hotspot (if any) the current address hits under the active scheme.
    always_comb begin
        hot_hit  = 1'b0;
        hot_bank = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (scheme == SCHEME_F4 && hit_f4[i]) begin
                hot_hit  = 1'b1;
                hot_bank = 3'(i);
            end
            if (i < 4) begin
                if (scheme == SCHEME_F6 && hit_f6[i]) begin
                    hot_hit  = 1'b1;
                    hot_bank = 3'(i);
                end
            end
            if (i < 2) begin
                if (scheme == SCHEME_F8 && hit_f8[i]) begin
                    hot_hit  = 1'b1;
                    hot_bank = 3'(i);
                end
            end
        end
    end

    // Bank as it will be after this access, masked to the width the scheme uses.
    // Masking happens on use so a scheme change never rewrites the register.
    always_comb begin
        bank_next = (cart_sel && hot_hit) ? hot_bank : bank_reg;
        bank_eff  = 3'd0;
        case (scheme)
            SCHEME_4K: bank_eff = 3'd0;
            SCHEME_F8: bank_eff = {2'b00, bank_next[0]};
            SCHEME_F6: bank_eff = {1'b0, bank_next[1:0]};
            SCHEME_F4: bank_eff = bank_next;
            default:   bank_eff = 3'd0;
        endcase
        fetch_address = {1'b0, slot, bank_eff, cpu_address[11:0]};
    end

    // Fetch sequencer; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            bank_reg       <= 3'd0;
            cpu_data_reg   <= 8'h00;
            cpu_ready_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            sd_address_reg <= 24'd0;
            sd_enable_reg  <= 1'b0;
        end else begin
            cpu_ready_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cart_strobe) begin
                        bank_reg       <= bank_next;
                        sd_address_reg <= fetch_address;
                        sd_enable_reg  <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Give the pager one cycle to register the request before busy is valid.
                    if (cart_strobe) begin
                        overrun_reg <= 1'b1;
                    end
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cart_strobe) begin
                        overrun_reg <= 1'b1;
                    end
                    if (!sd_busy) begin
                        cpu_data_reg  <= sd_data;
                        cpu_ready_reg <= 1'b1;
                        sd_enable_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    sd_enable_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_data   = cpu_data_reg;
    assign cpu_ready  = cpu_ready_reg;
    assign bank       = bank_reg;
    assign overrun    = overrun_reg;
    assign sd_address = sd_address_reg;
    assign sd_enable  = sd_enable_reg;

endmodule
